// File: rtl/boxcar_channel_scheduler_if.sv
// Sample/result handshake bundle for the boxcar channel scheduler.
// The master drives requests and accepts results; the slave is the scheduler.
interface boxcar_channel_scheduler_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 4
);
  localparam int CH_W = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0]            i_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_data;
  logic [NUM_CHANNELS-1:0]            o_ready;
  logic [NUM_CHANNELS-1:0]            i_clear;
  logic                               o_valid;
  logic signed [DATA_WIDTH-1:0]       o_data;
  logic [CH_W-1:0]                    o_channel;
  logic                               i_ready;

  modport master (
    output i_valid, i_data, i_clear, i_ready,
    input  o_ready, o_valid, o_data, o_channel
  );

  modport slave (
    input  i_valid, i_data, i_clear, i_ready,
    output o_ready, o_valid, o_data, o_channel
  );
endinterface

// File: rtl/boxcar_channel_scheduler.sv
// Round-robin scheduler feeding per-channel moving-average (boxcar) windows
// into a single registered result stage with valid/ready backpressure.
module boxcar_channel_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LOG2_WINDOW  = 2
) (
  input logic                        i_clk,
  input logic                        i_reset_n,
  boxcar_channel_scheduler_if.slave  bus
);
  localparam int WINDOW = 1 << LOG2_WINDOW;
  localparam int ACC_W  = DATA_WIDTH + LOG2_WINDOW;
  localparam int CH_W   = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1;
  localparam int FILL_W = LOG2_WINDOW + 1;

  // Floor mean: arithmetic shift rounds toward minus infinity.
  function automatic logic signed [DATA_WIDTH-1:0] window_mean(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> LOG2_WINDOW;
    return shifted[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] buf_q  [NUM_CHANNELS][WINDOW];
  logic signed [DATA_WIDTH-1:0] buf_d  [NUM_CHANNELS][WINDOW];
  logic signed [ACC_W-1:0]      acc_q  [NUM_CHANNELS];
  logic signed [ACC_W-1:0]      acc_d  [NUM_CHANNELS];
  logic [LOG2_WINDOW-1:0]       wr_ptr_q [NUM_CHANNELS];
  logic [LOG2_WINDOW-1:0]       wr_ptr_d [NUM_CHANNELS];
  logic [FILL_W-1:0]            fill_q [NUM_CHANNELS];
  logic [FILL_W-1:0]            fill_d [NUM_CHANNELS];
  logic [CH_W-1:0]              last_grant_q, last_grant_d;
  logic                         o_valid_q, o_valid_d;
  logic signed [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [CH_W-1:0]              o_channel_q, o_channel_d;

  logic [NUM_CHANNELS-1:0]      elig;
  logic [NUM_CHANNELS-1:0]      grant;
  logic [CH_W-1:0]              grant_idx;
  logic                         found;
  logic                         out_free;
  logic                         xfer;
  int                           idx;

  logic signed [DATA_WIDTH-1:0] x_s;
  logic signed [DATA_WIDTH-1:0] old_s;
  logic signed [ACC_W-1:0]      acc_new;
  logic [FILL_W-1:0]            fill_new;

  // Arbiter: depends only on control inputs and registered state, never on data.
  always_comb begin
    out_free  = !o_valid_q || bus.i_ready;
    elig      = bus.i_valid & ~bus.i_clear;
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = 0;
    for (int off = 1; off <= NUM_CHANNELS; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (!found && elig[idx]) begin
        found     = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
    if (found && out_free && i_reset_n) grant[grant_idx] = 1'b1;
    xfer = |grant;
  end

  assign bus.o_ready   = grant;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_channel = o_channel_q;

  always_comb begin
    buf_d        = buf_q;
    acc_d        = acc_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    last_grant_d = last_grant_q;
    o_valid_d    = o_valid_q;
    o_data_d     = o_data_q;
    o_channel_d  = o_channel_q;

    x_s      = bus.i_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    old_s    = (fill_q[grant_idx] == FILL_W'(WINDOW)) ? buf_q[grant_idx][wr_ptr_q[grant_idx]] : '0;
    acc_new  = acc_q[grant_idx] - ACC_W'(old_s) + ACC_W'(x_s);
    fill_new = (fill_q[grant_idx] == FILL_W'(WINDOW)) ? fill_q[grant_idx]
                                                      : fill_q[grant_idx] + FILL_W'(1);

    // A cleared channel is never eligible, so clear and transfer never collide.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (bus.i_clear[c]) begin
        acc_d[c]    = '0;
        wr_ptr_d[c] = '0;
        fill_d[c]   = '0;
      end
    end

    if (xfer) begin
      buf_d[grant_idx][wr_ptr_q[grant_idx]] = x_s;
      acc_d[grant_idx]    = acc_new;
      wr_ptr_d[grant_idx] = wr_ptr_q[grant_idx] + LOG2_WINDOW'(1);
      fill_d[grant_idx]   = fill_new;
      last_grant_d        = grant_idx;
    end

    if (xfer && fill_new == FILL_W'(WINDOW)) begin
      o_valid_d   = 1'b1;
      o_data_d    = window_mean(acc_new);
      o_channel_d = grant_idx;
    end else if (o_valid_q && bus.i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        acc_q[c]    <= '0;
        wr_ptr_q[c] <= '0;
        fill_q[c]   <= '0;
      end
      last_grant_q <= CH_W'(NUM_CHANNELS - 1);
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_channel_q  <= '0;
    end else begin
      acc_q        <= acc_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      last_grant_q <= last_grant_d;
      o_valid_q    <= o_valid_d;
      o_data_q     <= o_data_d;
      o_channel_q  <= o_channel_d;
    end
  end

  // Sample storage is masked by fill, so it needs no reset.
  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end
endmodule

// File: tb/tb_boxcar_channel_scheduler.sv
// Directed bench for boxcar_channel_scheduler (8-bit samples, 4 channels, window 4).
module tb_boxcar_channel_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  boxcar_channel_scheduler_if #(.DATA_WIDTH(8), .NUM_CHANNELS(4)) bus ();

  boxcar_channel_scheduler #(
    .DATA_WIDTH(8), .NUM_CHANNELS(4), .LOG2_WINDOW(2)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.i_valid = '0;
    bus.i_clear = '0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic send(input int ch, input int val, input string tag);
    logic [7:0] v;
    v           = val[7:0];
    bus.i_valid = 4'(1 << ch);
    bus.i_clear = '0;
    bus.i_data  = '0;
    bus.i_data[ch*8 +: 8] = v;
    #1;
    check({tag, "_rdy"}, bus.o_ready, 1 << ch);
    step();
    bus.i_valid = '0;
  endtask

  task automatic chk_out(input string tag, input int v, input int d, input int ch);
    check({tag, "_vld"}, bus.o_valid, v);
    if (v != 0) begin
      check({tag, "_dat"}, $signed(bus.o_data), d);
      check({tag, "_ch"}, bus.o_channel, ch);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_valid = 4'hF;
    bus.i_clear = '0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;
    #1;
    check("rst_rdy", bus.o_ready, 0);
    step();
    check("rst_vld", bus.o_valid, 0);
    check("rst_dat", bus.o_data, 0);
    check("rst_ch", bus.o_channel, 0);
    do_reset();

    // Warm-up on channel 0
    send(0, 4, "wu1");  chk_out("wu1", 0, 0, 0);
    send(0, 8, "wu2");  chk_out("wu2", 0, 0, 0);
    send(0, 12, "wu3"); chk_out("wu3", 0, 0, 0);
    send(0, 16, "wu4"); chk_out("wu4", 1, 10, 0);
    send(0, 20, "wu5"); chk_out("wu5", 1, 14, 0);
    step();
    check("wu_idle_vld", bus.o_valid, 0);

    // Round-robin with every channel requesting
    do_reset();
    bus.i_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr%0d", k), bus.o_ready, 1 << (k % 4));
      step();
    end
    bus.i_valid = '0;

    // Backpressure holds the result and blocks grants
    do_reset();
    for (int k = 0; k < 4; k++) send(0, 5, "bp_fill");
    chk_out("bp_full", 1, 5, 0);
    bus.i_ready = 1'b0;
    bus.i_valid = 4'b0010;
    bus.i_data  = 32'h0000_0700;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_rdy%0d", k), bus.o_ready, 0);
      step();
      chk_out($sformatf("bp_hold%0d", k), 1, 5, 0);
    end
    bus.i_ready = 1'b1;
    #1;
    check("bp_release_rdy", bus.o_ready, 4'b0010);
    step();
    check("bp_pop_vld", bus.o_valid, 0);
    bus.i_valid = '0;

    // Signed floor on channel 1
    do_reset();
    for (int k = 0; k < 4; k++) send(1, -128, "sg_fill");
    chk_out("sg_min", 1, -128, 1);
    send(1, 127, "sg_mix");
    chk_out("sg_floor", 1, -65, 1);

    // Clear has priority and restarts the window
    do_reset();
    for (int k = 0; k < 3; k++) send(2, 9, "cl_pre");
    bus.i_valid = 4'b0100;
    bus.i_clear = 4'b0100;
    bus.i_data  = 32'h0009_0000;
    #1;
    check("cl_rdy", bus.o_ready, 0);
    step();
    check("cl_vld", bus.o_valid, 0);
    bus.i_clear = '0;
    send(2, 1, "cl1"); chk_out("cl1", 0, 0, 0);
    send(2, 1, "cl2"); chk_out("cl2", 0, 0, 0);
    send(2, 1, "cl3"); chk_out("cl3", 0, 0, 0);
    send(2, 1, "cl4"); chk_out("cl4", 1, 1, 2);

    // Reset mid-stream discards held result and partial windows
    do_reset();
    send(3, 100, "mr_a");
    send(3, 100, "mr_b");
    for (int k = 0; k < 4; k++) send(0, 6, "mr_fill");
    chk_out("mr_held", 1, 6, 0);
    bus.i_ready = 1'b0;
    rst_n       = 1'b0;
    bus.i_valid = 4'b1001;
    bus.i_data  = 32'h0800_0006;
    #1;
    check("mr_rst_rdy", bus.o_ready, 0);
    step();
    check("mr_rst_vld", bus.o_valid, 0);
    check("mr_rst_dat", bus.o_data, 0);
    rst_n       = 1'b1;
    bus.i_ready = 1'b1;
    #1;
    check("mr_first_grant", bus.o_ready, 4'b0001);
    step();
    send(3, 8, "mr3_1"); chk_out("mr3_1", 0, 0, 0);
    send(3, 8, "mr3_2"); chk_out("mr3_2", 0, 0, 0);
    send(3, 8, "mr3_3"); chk_out("mr3_3", 0, 0, 0);
    send(3, 8, "mr3_4"); chk_out("mr3_4", 1, 8, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/boxcar_channel_scheduler.md
BOXCAR_CHANNEL_SCHEDULER -- requirements
Module: boxcar_channel_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: signed sample width, in and out.
REQ-002 The block SHALL have parameter NUM_CHANNELS, default 4: number of independent requesters, minimum 2.
REQ-003 The block SHALL have parameter LOG2_WINDOW, default 2: per-channel window is WINDOW = 2^LOG2_WINDOW samples, minimum 1.
REQ-004 The block SHALL have port i_clk, input, 1: clock, all state updates on rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have port i_valid, input, NUM_CHANNELS: per-channel sample request.
REQ-007 The block SHALL have port i_data, input, NUM_CHANNELS*DATA_WIDTH: packed signed samples, channel c in bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port o_ready, output, NUM_CHANNELS: one-hot grant; a sample transfers when i_valid[c] && o_ready[c].
REQ-009 The block SHALL have port i_clear, input, NUM_CHANNELS: per-channel window clear.
REQ-010 The block SHALL have port o_valid, output, 1: registered result valid.
REQ-011 The block SHALL have port o_data, output, DATA_WIDTH: signed registered window mean.
REQ-012 The block SHALL have port o_channel, output, max(1,$clog2(NUM_CHANNELS)): channel of o_data.
REQ-013 The block SHALL have port i_ready, input, 1: downstream accepts the result when o_valid && i_ready.

Function
REQ-014 Each channel SHALL keep private state: a WINDOW-deep sample buffer, a signed accumulator of DATA_WIDTH+LOG2_WINDOW bits, a LOG2_WINDOW-bit write pointer, and a fill count saturating at WINDOW.
REQ-015 The output stage SHALL be free when !o_valid || i_ready; o_ready SHALL be all-zero while the output stage is not free.
REQ-016 Eligible requesters SHALL be channels with i_valid[c]=1 and i_clear[c]=0.
REQ-017 When the output stage is free, the arbiter SHALL grant at most one eligible channel per cycle, round-robin, searching from last_grant+1 upward with wrap.
REQ-018 last_grant SHALL update only on an actual transfer.
REQ-019 o_ready SHALL be combinational from i_valid, i_clear, last_grant, o_valid and i_ready, with no combinational path from i_data.
REQ-020 On transfer of sample x on channel c, old SHALL equal buf[c][wr_ptr[c]] if fill[c]==WINDOW, else 0.
REQ-021 On that transfer, acc[c] SHALL update to acc[c]-old+x with no overflow possible at the stated width.
REQ-022 On that transfer, buf[c][wr_ptr[c]] SHALL be written with x.
REQ-023 On that transfer, wr_ptr[c] SHALL increment modulo WINDOW.
REQ-024 On that transfer, fill[c] SHALL increment, saturating at WINDOW.
REQ-025 If the post-update fill[c]==WINDOW, the next cycle SHALL show o_valid=1, o_channel=c and o_data=acc_new>>>LOG2_WINDOW (arithmetic shift, floor), giving 1-cycle latency.
REQ-026 If the post-update fill[c]<WINDOW, no result SHALL be produced and o_valid SHALL clear if the output stage was popped that cycle.
REQ-027 While o_valid && !i_ready, o_valid, o_data and o_channel SHALL hold stable.
REQ-028 A pop and a new transfer in the same cycle SHALL be allowed, giving full throughput of 1 sample per cycle.
REQ-029 i_clear[c]=1 SHALL zero acc[c], wr_ptr[c] and fill[c] next cycle; buffer contents are not cleared and are masked by fill.
REQ-030 i_clear[c] SHALL take priority over a simultaneous i_valid[c], so no transfer occurs on that channel that cycle.
REQ-031 i_clear SHALL NOT affect a result already held in the output register.
REQ-032 Channels SHALL be fully independent: a transfer or clear on c SHALL not alter any other channel's state.

Reset
REQ-033 While i_reset_n=0, o_ready SHALL be all-zero.
REQ-034 On reset, o_valid, o_data and o_channel SHALL be 0.
REQ-035 On reset, all acc, wr_ptr and fill SHALL be 0.
REQ-036 On reset, last_grant SHALL be NUM_CHANNELS-1, so channel 0 wins first.
REQ-037 Reset asserted mid-operation SHALL discard any held result and all partial windows; the first cycle after release behaves as power-up.

Verification (DATA_WIDTH=8, NUM_CHANNELS=4, LOG2_WINDOW=2, i_ready=1 unless stated)
REQ-038 Warm-up: ch0 sends 4,8,12,16 then 20 -> no o_valid for first three; o_data=10, ch0 one cycle after 4th; o_data=14 after 5th.
REQ-039 Round-robin: i_valid=4'b1111 held -> grants 0,1,2,3,0,1 on consecutive cycles, one-hot o_ready each cycle.
REQ-040 Backpressure: o_valid=1, i_ready=0 for 3 cycles -> o_data/o_channel stable, o_ready=0; on i_ready=1, pop and new grant same cycle.
REQ-041 Sign/floor: ch1 sends -128 x4 then 127 -> o_data=-128, then acc=-257, o_data=-65.
REQ-042 Clear: ch2 sends 3 samples, i_clear[2]=1 with i_valid[2]=1 (no transfer), then 1,1,1,1 -> single output o_data=1 on 4th post-clear sample.
REQ-043 Reset mid-stream: assert i_reset_n=0 with o_valid=1 and ch3 at fill 2 -> o_valid=0; ch3 then needs 4 new samples for first output; channel 0 granted first.
